button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 The block SHALL have parameter LONG_COUNTS, default 50_000_000, meaning press cycles before long-press (1 s at 50 MHz); legal range 2..2^26-1.
REQ-002 The block SHALL have parameter REPEAT_COUNTS, default 10_000_000, meaning cycles between auto-repeat pulses while long-held; legal range 2..2^26-1.
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port button_level, input, 1, debounced, clk-synchronous button level; 1 = pressed.
REQ-006 The block SHALL have port press_pulse, output, 1, one-cycle strobe on press.
REQ-007 The block SHALL have port click_pulse, output, 1, one-cycle strobe on release before long-press.
REQ-008 The block SHALL have port long_pulse, output, 1, one-cycle strobe when long-press threshold is reached.
REQ-009 The block SHALL have port repeat_pulse, output, 1, one-cycle strobe at each auto-repeat interval while long-held.
REQ-010 The block SHALL have port release_pulse, output, 1, one-cycle strobe on any release.
REQ-011 The block SHALL have port held, output, 1, level high in states PRESSED and LONG_HELD.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from button_level to any output.
REQ-013 The FSM SHALL have states WAIT_LOW, IDLE, PRESSED and LONG_HELD, plus one 26-bit counter.
REQ-014 WAIT_LOW: if button_level=0, the FSM SHALL go to IDLE; otherwise it SHALL stay, generating no pulses, so a button already held at reset is never reported.
REQ-015 IDLE: if button_level=1, the FSM SHALL go to PRESSED, clear the counter, and assert press_pulse and held on the following cycle.
REQ-016 PRESSED with button_level=1 and counter≠LONG_COUNTS-1: the counter SHALL increment by 1.
REQ-017 PRESSED with button_level=1 and counter=LONG_COUNTS-1: the FSM SHALL go to LONG_HELD, clear the counter, and assert long_pulse next cycle, so long_pulse falls exactly LONG_COUNTS cycles after press_pulse.
REQ-018 LONG_HELD with button_level=1: the counter SHALL increment, and at REPEAT_COUNTS-1 it SHALL wrap to 0 and assert repeat_pulse next cycle, so the first repeat is REPEAT_COUNTS cycles after long_pulse and each later repeat is REPEAT_COUNTS cycles apart.
REQ-019 PRESSED with button_level=0: the FSM SHALL go to IDLE and assert release_pulse and click_pulse together next cycle.
REQ-020 LONG_HELD with button_level=0: the FSM SHALL go to IDLE and assert release_pulse only, with no click_pulse.
REQ-021 When release coincides with a threshold cycle (counter at LONG_COUNTS-1 or REPEAT_COUNTS-1 with button_level=0), release SHALL take priority, with no long_pulse or repeat_pulse issued.
REQ-022 Each pulse output SHALL be high for exactly one cycle per event, and at most one of press/long/repeat/release SHALL be high in any cycle.
REQ-023 A one-cycle press (1 then 0) SHALL produce press_pulse followed by release_pulse+click_pulse on the next cycle.
REQ-024 The counter SHALL never exceed max(LONG_COUNTS,REPEAT_COUNTS)-1, and no wrap SHALL occur outside REQ-018.

Reset
REQ-025 While reset=1 at a clk edge, state SHALL go to WAIT_LOW, the counter SHALL be 0, and all outputs SHALL be 0 on the next cycle.
REQ-026 reset SHALL take priority over all transitions, and reset mid-hold SHALL drop held and emit no release_pulse.
REQ-027 After reset, no press SHALL be reported until button_level has been sampled 0 at least once.

Verification (LONG_COUNTS=8, REPEAT_COUNTS=4)
REQ-028 Short press: level 0→1 for 3 cycles, then 0 -> press_pulse ×1; 3 cycles later release_pulse+click_pulse ×1; no long_pulse.
REQ-029 Long hold: level held 1 for 20 cycles -> press_pulse at T, long_pulse at T+8, repeat_pulse at T+12 and T+16, then release_pulse only, no click_pulse.
REQ-030 Boundary release: level 1 for exactly 7 cycles after press_pulse, then 0 on the threshold cycle -> click_pulse+release_pulse, no long_pulse.
REQ-031 Reset while held: assert reset in LONG_HELD with level kept 1 -> all outputs 0, no press_pulse until level goes 0 then 1 again.
REQ-032 Single-cycle glitch: level 1 for one cycle from IDLE -> press_pulse, then release_pulse+click_pulse on the next cycle; held high for exactly 1 cycle.
REQ-033 Every scenario SHALL be checked by assertion that the pulses are mutually exclusive per REQ-022 and that each strobe lasts one cycle.

Source files
------------

// File: rtl/button_event.sv
// Button gesture decoder: turns a debounced level into press, click, long-press,
// auto-repeat and release strobes. All outputs are registered.
module button_event #(
    parameter int LONG_COUNTS   = 50_000_000,
    parameter int REPEAT_COUNTS = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_level,
    output logic press_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    // state     | meaning
    // WAIT_LOW  | after reset, waiting for the button to be seen released
    // IDLE      | released, waiting for a press
    // PRESSED   | held, counting toward the long-press threshold
    // LONG_HELD | long-press reached, counting auto-repeat intervals
    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        IDLE      = 2'd1,
        PRESSED   = 2'd2,
        LONG_HELD = 2'd3
    } state_t;

    localparam logic [25:0] LONG_TC   = 26'(LONG_COUNTS - 1);
    localparam logic [25:0] REPEAT_TC = 26'(REPEAT_COUNTS - 1);

    state_t      state;
    logic [25:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_LOW;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                WAIT_LOW: begin
                    held <= 1'b0;
                    if (!button_level) state <= IDLE;
                end
                IDLE: begin
                    held <= 1'b0;
                    if (button_level) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release wins over a coincident long-press threshold.
                    if (!button_level) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        click_pulse   <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == LONG_TC) begin
                        state      <= LONG_HELD;
                        cnt        <= '0;
                        long_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 26'd1;
                    end
                end
                LONG_HELD: begin
                    if (!button_level) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == REPEAT_TC) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 26'd1;
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_COUNTS=8, REPEAT_COUNTS=4.
// Output vector order: {press, click, long, repeat, release, held}.
module tb_button_event;

    logic clk = 1'b0;
    logic reset;
    logic button_level;
    logic press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held;

    int n_checks = 0;
    int n_fails  = 0;
    logic [4:0] prev_pulses = '0;

    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] PRESS = 6'b100001;
    localparam logic [5:0] HELD  = 6'b000001;
    localparam logic [5:0] LONG  = 6'b001001;
    localparam logic [5:0] REPT  = 6'b000101;
    localparam logic [5:0] CLICK = 6'b010010;
    localparam logic [5:0] REL   = 6'b000010;

    button_event #(.LONG_COUNTS(8), .REPEAT_COUNTS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .click_pulse  (click_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held};
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge, then apply per-cycle exclusivity and one-cycle strobe checks.
    task automatic tick();
        logic [4:0] cur;
        @(posedge clk);
        #1;
        cur = {press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse};
        n_checks++;
        assert ($onehot0({press_pulse, long_pulse, repeat_pulse, release_pulse}) &&
                !(click_pulse && !release_pulse)) else begin
            n_fails++;
            $error("FAIL exclusive: observed %b expected at most one strobe", cur);
        end
        n_checks++;
        assert ((cur & prev_pulses) === 5'b0) else begin
            n_fails++;
            $error("FAIL one_cycle: observed %b after %b expected no repeat", cur, prev_pulses);
        end
        prev_pulses = cur;
    endtask

    task automatic step(input logic lvl, input string tag, input logic [5:0] exp);
        button_level = lvl;
        tick();
        chk(tag, outs(), exp);
    endtask

    initial begin
        reset = 1'b1;
        button_level = 1'b0;
        tick();
        tick();
        chk("reset_state", outs(), NONE);
        reset = 1'b0;
        step(1'b0, "wait_low_exit", NONE);

        // Short press: 3 cycles high
        step(1'b1, "short_press", PRESS);
        step(1'b1, "short_hold1", HELD);
        step(1'b1, "short_hold2", HELD);
        step(1'b0, "short_click", CLICK);
        step(1'b0, "short_idle", NONE);

        // Long hold: 20 cycles high
        for (int i = 0; i < 20; i++) begin
            logic [5:0] e;
            e = (i == 0) ? PRESS : (i == 8) ? LONG : (i == 12 || i == 16) ? REPT : HELD;
            step(1'b1, $sformatf("long_hold_%0d", i), e);
        end
        step(1'b0, "long_release", REL);
        step(1'b0, "long_idle", NONE);

        // Release on the long-press threshold cycle
        step(1'b1, "bnd_press", PRESS);
        for (int i = 0; i < 7; i++) step(1'b1, $sformatf("bnd_hold_%0d", i), HELD);
        step(1'b0, "bnd_click", CLICK);
        step(1'b0, "bnd_idle", NONE);

        // Reset while long-held
        step(1'b1, "rst_press", PRESS);
        for (int i = 1; i < 8; i++) step(1'b1, $sformatf("rst_hold_%0d", i), HELD);
        step(1'b1, "rst_long", LONG);
        reset = 1'b1;
        step(1'b1, "rst_in_long", NONE);
        reset = 1'b0;
        step(1'b1, "rst_wait_low0", NONE);
        step(1'b1, "rst_wait_low1", NONE);
        step(1'b1, "rst_wait_low2", NONE);
        step(1'b0, "rst_seen_low", NONE);
        step(1'b1, "rst_repress", PRESS);
        step(1'b1, "rst_repress_hold", HELD);
        step(1'b0, "rst_click", CLICK);

        // Single-cycle glitch
        step(1'b0, "glitch_idle", NONE);
        step(1'b1, "glitch_press", PRESS);
        step(1'b0, "glitch_click", CLICK);
        step(1'b0, "glitch_after", NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
